// File: rtl/wb_stream_pkg.sv
// Purpose: shared constants, FSM encoding and helpers for the WB burst-read stream block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: CTI/BTE codes, FSM state type, bytes-per-word helper.
package wb_stream_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bytes per bus word; the address step between beats.
  function automatic int wsb(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wb_stream_writer_fifo.sv
// Purpose: first-word-fall-through synchronous FIFO with occupancy output.
// Latency: a written word is visible on rd_data/rd_valid one cycle after the write.
// Backpressure: writes are dropped when full unless a read frees a slot in the same cycle.
// Ports: clk/rst (async active-low), wr_en/wr_data push, rd_en pop, rd_data head word,
//        rd_valid not-empty, count occupancy (AW+1 bits).
module wb_stream_writer_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW:0]      count
);

  localparam int DEPTH = 2**AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign rd_ok    = rd_en && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_ok    = wr_en && ((count != (AW+1)'(DEPTH)) || rd_ok);
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/wb_stream_writer.sv
// Purpose: Wishbone burst-read master streaming a memory buffer out as valid/ready words.
// Latency: bus ack to stream_valid is one cycle (through the FWFT FIFO).
// Backpressure: a burst starts only when the FIFO can absorb it whole; stream_ready stalls drain.
// Ports: clk/rst (async active-low); enable, start_adr, buf_size, burst_size config;
//        busy/irq/err status; wbm_* Wishbone master; stream_data/valid/ready output stream.
module wb_stream_writer
  import wb_stream_pkg::*;
#(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 5,
  parameter int MAX_BURST_LEN = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [31:0]        buf_size,
  input  logic [31:0]        burst_size,
  output logic               busy,
  output logic               irq,
  output logic               err,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  output logic [WB_DW-1:0]   stream_data,
  output logic               stream_valid,
  input  logic               stream_ready
);

  localparam int WSB   = wsb(WB_DW);
  localparam int BCW   = $clog2(MAX_BURST_LEN) + 1;
  localparam int DEPTH = 2**FIFO_AW;

  state_t           state, state_nxt;
  logic [WB_AW-1:0] cur_adr, adr_q;
  logic [31:0]      remaining, burst_cfg;
  logic [BCW-1:0]   beats_left, len_q;
  logic [FIFO_AW:0] fifo_cnt;
  logic [31:0]      len_w, free_w, rem_after;
  logic             good_ack, final_ack, err_q, irq_q;

  assign len_w     = (burst_cfg < remaining) ? burst_cfg : remaining;
  assign free_w    = 32'(DEPTH) - 32'(fifo_cnt);
  assign rem_after = remaining - 32'(len_q);
  // err beats any ack in the same cycle; a retry never counts as a beat.
  assign good_ack  = (state == BURST) && wbm_ack_i && !wbm_err_i && !wbm_rty_i;
  assign final_ack = good_ack && (beats_left == BCW'(1));

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = '0;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = 1'b0;
  assign wbm_bte_o = BTE_LINEAR;
  assign irq       = irq_q;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (enable && !err_q) state_nxt = WAIT;
      WAIT: begin
        if (!enable)              state_nxt = IDLE;
        else if (free_w >= len_w) state_nxt = BURST;
      end
      BURST: begin
        if (wbm_err_i) state_nxt = IDLE;
        else if (final_ack) begin
          if (rem_after == '0) state_nxt = DONE;
          else if (!enable)    state_nxt = IDLE;
          else                 state_nxt = WAIT;
        end
      end
      DONE:    state_nxt = enable ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_cti_o = CTI_CLASSIC;
    busy      = 1'b0;
    case (state)
      WAIT: busy = 1'b1;
      BURST: begin
        busy      = 1'b1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_cti_o = (beats_left == BCW'(1)) ? CTI_EOB : CTI_INC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_adr    <= '0;
      adr_q      <= '0;
      remaining  <= '0;
      burst_cfg  <= '0;
      beats_left <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (!enable) err_q <= 1'b0;
      // Each buffer pass (fresh or looped) re-samples the config.
      if ((state == IDLE || state == DONE) && state_nxt == WAIT) begin
        cur_adr   <= start_adr;
        remaining <= buf_size;
        burst_cfg <= burst_size;
      end
      if (state == WAIT && state_nxt == BURST) begin
        adr_q      <= cur_adr;
        beats_left <= BCW'(len_w);
        len_q      <= BCW'(len_w);
      end
      if (state == BURST) begin
        if (wbm_err_i) begin
          err_q <= 1'b1;
        end else if (good_ack) begin
          adr_q      <= adr_q + WB_AW'(WSB);
          beats_left <= beats_left - 1'b1;
          if (final_ack) begin
            remaining <= rem_after;
            cur_adr   <= adr_q + WB_AW'(WSB);
            if (rem_after == '0) irq_q <= 1'b1;
          end
        end
      end
    end
  end

  wb_stream_writer_fifo #(
    .WIDTH (WB_DW),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (good_ack),
    .wr_data  (wbm_dat_i),
    .rd_en    (stream_ready),
    .rd_data  (stream_data),
    .rd_valid (stream_valid),
    .count    (fifo_cnt)
  );

endmodule

// File: tb/tb_wb_stream_writer.sv
`timescale 1ns/1ps
module tb_wb_stream_writer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] start_adr, buf_size, burst_size;
  logic        busy, irq, err;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [31:0] stream_data;
  logic        stream_valid;
  logic        stream_ready;

  wb_stream_writer #(
    .WB_AW(32), .WB_DW(32), .FIFO_AW(3), .MAX_BURST_LEN(128)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
    .busy(busy), .irq(irq), .err(err),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbm_rty_i(wbm_rty_i),
    .stream_data(stream_data), .stream_valid(stream_valid), .stream_ready(stream_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic [2:0]  cti;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_words[$];

  int n_checks = 0;
  int n_errors = 0;
  int ready_mode = 1;   // 0 random, 1 always ready, 2 stalled
  int acked_total = 0;
  int err_at = -1;
  int rty_at = -1;
  int rty_target = 0;
  int rty_done = 0;
  int irq_cnt = 0;
  bit err_pending = 1'b0;
  bit hold_prev = 1'b0;
  bit irq_prev = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  // Reference model: walk the buffer in bursts of min(burst, remaining).
  // err_beat >= 0 truncates the pass: that beat is the errored one, its word is lost.
  task automatic plan(input logic [31:0] sa, input int bs, input int bu, input int err_beat);
    logic [31:0] a;
    int rem;
    int k;
    int len;
    beat_t b;
    a = sa;
    rem = bs;
    k = 0;
    while (rem > 0) begin
      len = (bu < rem) ? bu : rem;
      for (int i = 0; i < len; i++) begin
        b.adr = a;
        b.cti = (i == len - 1) ? 3'b111 : 3'b010;
        if (err_beat < 0 || k <= err_beat) exp_beats.push_back(b);
        if (err_beat < 0 || k < err_beat) exp_words.push_back(a >> 2);
        a = a + 32'd4;
        k++;
      end
      rem -= len;
    end
  endtask

  // Wishbone slave: RAM word = byte address / 4, random wait states,
  // scheduled retry and error injection. Responses change on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    if (err_pending) begin
      check("cyc_drop_after_err", 32'(wbm_cyc_o), 32'd0);
      err_pending = 1'b0;
    end
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = wbm_adr_o >> 2;
    if (rst && wbm_cyc_o && wbm_stb_o) begin
      if (exp_beats.size() == 0) begin
        fail("unexpected_beat");
      end else begin
        b = exp_beats[0];
        if (acked_total == err_at) begin
          wbm_err_i = 1'b1;
          wbm_ack_i = 1'b1;
          check("err_beat_adr", wbm_adr_o, b.adr);
          void'(exp_beats.pop_front());
          err_pending = 1'b1;
        end else if (acked_total == rty_at && rty_done < rty_target) begin
          wbm_rty_i = 1'b1;
          rty_done++;
          check("rty_adr", wbm_adr_o, b.adr);
        end else if ($urandom_range(0, 3) != 0) begin
          wbm_ack_i = 1'b1;
          check("beat_adr", wbm_adr_o, b.adr);
          check("beat_cti", 32'(wbm_cti_o), 32'(b.cti));
          void'(exp_beats.pop_front());
          acked_total++;
        end
      end
    end
  end

  // Stream monitor: drives ready, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (hold_prev && stream_valid && rst) check("stream_stable", stream_data, prev_data);
    case (ready_mode)
      0:       stream_ready = 1'($urandom_range(0, 1));
      1:       stream_ready = 1'b1;
      default: stream_ready = 1'b0;
    endcase
    if (rst && stream_valid && stream_ready) begin
      if (exp_words.size() == 0) fail("unexpected_word");
      else check("stream_word", stream_data, exp_words.pop_front());
    end
    hold_prev = stream_valid && !stream_ready;
    prev_data = stream_data;
  end

  always @(negedge clk) begin
    if (irq) begin
      irq_cnt++;
      if (irq_prev) fail("irq_width");
    end
    irq_prev = irq;
  end

  task automatic wait_irq(input string name, input int budget);
    int n = 0;
    while (!irq && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_irq_seen"}, 32'(irq), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_words.size() != 0 || exp_beats.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(n < budget), 32'd1);
  endtask

  task automatic config_run(input logic [31:0] sa, input int bs, input int bu);
    start_adr  = sa;
    buf_size   = 32'(bs);
    burst_size = 32'(bu);
    enable     = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    enable = 1'b0;
    start_adr = '0;
    buf_size = 32'd1;
    burst_size = 32'd1;
    repeat (3) @(negedge clk);
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_cti", 32'(wbm_cti_o), 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_valid", 32'(stream_valid), 32'd0);
    check("tie_sel", 32'(wbm_sel_o), 32'hF);
    check("tie_we", 32'(wbm_we_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: single full burst
    ready_mode = 1;
    plan(32'h0, 8, 8, -1);
    config_run(32'h0, 8, 8);
    wait_irq("t1", 400);
    enable = 1'b0;
    wait_drain("t1", 400);
    check("t1_irq_cnt", 32'(irq_cnt), 32'd1);

    // 2: truncated last burst, random backpressure
    ready_mode = 0;
    plan(32'h0, 10, 4, -1);
    config_run(32'h0, 10, 4);
    wait_irq("t2", 600);
    enable = 1'b0;
    wait_drain("t2", 600);
    check("t2_irq_cnt", 32'(irq_cnt), 32'd2);

    // 3: stalled consumer, second burst must wait for FIFO space
    ready_mode = 2;
    plan(32'h40, 16, 8, -1);
    config_run(32'h40, 16, 8);
    repeat (50) @(negedge clk);
    check("t3_beats_left", 32'(exp_beats.size()), 32'd8);
    check("t3_cyc_idle", 32'(wbm_cyc_o), 32'd0);
    check("t3_valid", 32'(stream_valid), 32'd1);
    check("t3_words_left", 32'(exp_words.size()), 32'd16);
    ready_mode = 0;
    wait_irq("t3", 800);
    enable = 1'b0;
    wait_drain("t3", 800);
    check("t3_irq_cnt", 32'(irq_cnt), 32'd3);

    // 4: two retry cycles on the third beat
    ready_mode = 1;
    rty_at = acked_total + 2;
    rty_target = rty_done + 2;
    plan(32'h0, 8, 8, -1);
    config_run(32'h0, 8, 8);
    wait_irq("t4", 400);
    enable = 1'b0;
    wait_drain("t4", 400);
    check("t4_rty_used", 32'(rty_done), 32'(rty_target));
    rty_at = -1;

    // 5: bus error on the fifth beat (ack asserted alongside)
    err_at = acked_total + 4;
    plan(32'h0, 8, 8, 4);
    config_run(32'h0, 8, 8);
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t5_err_set", 32'(err), 32'd1);
    err_at = -1;
    repeat (20) @(negedge clk);
    check("t5_err_sticky", 32'(err), 32'd1);
    check("t5_no_restart", 32'(busy), 32'd0);
    wait_drain("t5", 400);
    check("t5_irq_cnt", 32'(irq_cnt), 32'd4);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_err_clear", 32'(err), 32'd0);

    // 6: continuous loop mode, then async reset mid-burst
    ready_mode = 0;
    plan(32'h0, 8, 4, -1);
    plan(32'h0, 8, 4, -1);
    config_run(32'h0, 8, 4);
    wait_irq("t6a", 600);
    @(negedge clk);
    wait_irq("t6b", 600);
    check("t6_two_passes", 32'(exp_beats.size()), 32'd0);
    plan(32'h0, 8, 4, -1);
    n = acked_total;
    while (acked_total < n + 2 && n < 1000000) begin
      @(negedge clk);
      if (acked_total < n + 2 && $time > 400000) n = 1000000;
    end
    check("t6_third_pass", 32'(acked_total >= n + 2), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("t6_rst_valid", 32'(stream_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    exp_beats.delete();
    exp_words.delete();
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_idle_cyc", 32'(wbm_cyc_o), 32'd0);
    check("t6_idle_valid", 32'(stream_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
